// File: rtl/lio_tx_scheduler.sv
// Round-robin scheduler sharing one LightIO LED encoder between NUM_REQ packet
// sources. A granted word is held on enc_data while the encoder is taken through
// reset, enabled until done (or timeout), and the source is then acknowledged.
//
// Optional build macro: LIO_TX_SRC_HEADER_EN
//   defined   - every grant sends a header word {1..1, grant_id} followed by the
//               payload word, with one ack after the payload.
//   undefined - payload only; no header state is built.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | encoder held in reset, waiting for any req
// LOAD  | word latched, encoder reset held for RESET_CYCLES
// SEND  | encoder enabled, waiting for enc_done or timeout
// ACK   | one-cycle ack pulse to the granted source
// GAP   | encoder in reset for GAP_CYCLES before the next grant
module lio_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int PACKET_SIZE    = 8,
    parameter int RESET_CYCLES   = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*PACKET_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic [2:0]                     grant_id,
    output logic                           busy,
    output logic                           timeout_err,
    output logic                           enc_reset,
    output logic                           enc_enable,
    output logic [PACKET_SIZE-1:0]         enc_data,
    input  logic                           enc_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_ACK,
        S_GAP
    } state_t;

    // One shared down-counter covers the reset hold, send timeout and gap.
    localparam int CNT_MAX_A = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RESET_LOAD   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             rr_last;
    logic                   any_req;
    logic [2:0]             pick_id;
    logic [PACKET_SIZE-1:0] pick_word;
    logic [NUM_REQ-1:0]     req_sh;
    int                     cand;
    logic                   cnt_zero;

`ifdef LIO_TX_SRC_HEADER_EN
    logic                   hdr_phase;
    logic [PACKET_SIZE-1:0] payload_q;
`endif

    assign cnt_zero = (cnt == '0);

    // Round-robin search starting just after the last served source.
    always_comb begin
        any_req = 1'b0;
        pick_id = '0;
        cand    = 0;
        req_sh  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(rr_last) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            req_sh = req >> cand;
            if (!any_req && req_sh[0]) begin
                any_req = 1'b1;
                pick_id = 3'(cand);
            end
        end
        pick_word = PACKET_SIZE'(req_data >> (int'(pick_id) * PACKET_SIZE));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (any_req) state_nxt = S_LOAD;
            S_LOAD: if (cnt_zero) state_nxt = S_SEND;
            S_SEND: begin
                if (enc_done) begin
`ifdef LIO_TX_SRC_HEADER_EN
                    state_nxt = hdr_phase ? S_LOAD : S_ACK;
`else
                    state_nxt = S_ACK;
`endif
                end else if (cnt_zero) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK:  state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:  if (cnt_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; encoder runs only while in SEND.
    always_comb begin
        busy       = (state != S_IDLE);
        enc_enable = (state == S_SEND);
        enc_reset  = (state != S_SEND);
        ack        = '0;
        if (state == S_ACK) begin
            ack = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
        end
    end

    // Down-counter reloaded on every state entry, counting to zero inside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            case (state_nxt)
                S_LOAD:  cnt <= RESET_LOAD;
                S_SEND:  cnt <= TIMEOUT_LOAD;
                S_GAP:   cnt <= GAP_LOAD;
                default: cnt <= '0;
            endcase
        end else if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Grant bookkeeping, encoder word and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_id    <= '0;
            rr_last     <= 3'(NUM_REQ - 1);
            enc_data    <= '0;
            timeout_err <= 1'b0;
`ifdef LIO_TX_SRC_HEADER_EN
            hdr_phase   <= 1'b0;
            payload_q   <= '0;
`endif
        end else begin
            if (state == S_IDLE && any_req) begin
                grant_id <= pick_id;
                rr_last  <= pick_id;
`ifdef LIO_TX_SRC_HEADER_EN
                enc_data  <= {{(PACKET_SIZE-3){1'b1}}, pick_id};
                payload_q <= pick_word;
                hdr_phase <= 1'b1;
`else
                enc_data <= pick_word;
`endif
            end
            if (state == S_SEND && !enc_done && cnt_zero) begin
                timeout_err <= 1'b1;
            end
`ifdef LIO_TX_SRC_HEADER_EN
            // Header finished (or timed out): payload follows only on a clean done.
            if (state == S_SEND && hdr_phase && (enc_done || cnt_zero)) begin
                hdr_phase <= 1'b0;
                if (enc_done) begin
                    enc_data <= payload_q;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_lio_tx_scheduler.sv
// Bench for lio_tx_scheduler: a transaction-level model walks each packet
// (grant, reset hold, send, ack, gap) and publishes the expected outputs for
// every cycle; one compare process checks the DUT against them on the falling edge.
module tb_lio_tx_scheduler;

    localparam int N = 4;
    localparam int P = 8;
    localparam int R = 2;
    localparam int G = 4;
    localparam int T = 1024;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*P-1:0] req_data;
    logic           enc_done;
    logic [N-1:0]   ack;
    logic [2:0]     grant_id;
    logic           busy;
    logic           timeout_err;
    logic           enc_reset;
    logic           enc_enable;
    logic [P-1:0]   enc_data;

    lio_tx_scheduler #(
        .NUM_REQ(N), .PACKET_SIZE(P), .RESET_CYCLES(R),
        .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
        .enc_reset(enc_reset), .enc_enable(enc_enable), .enc_data(enc_data),
        .enc_done(enc_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // expected outputs for the current cycle
    bit           chk_en = 1'b0;
    bit           exp_busy, exp_rst, exp_en, exp_terr;
    logic [N-1:0] exp_ack;
    logic [2:0]   exp_grant;
    logic [P-1:0] exp_data;

    // model state
    int           rr_last;
    int           m_grant;
    logic [P-1:0] m_data;
    bit           m_terr;
    bit           in_pkt;

    // source / encoder stub state
    int           src_mode;      // 0 random sources, 1 fixed held mask
    logic [N-1:0] pend;
    logic [P-1:0] sdata [N];
    bit           done_never;
    bit           rst_drive;

    int           grant_log [$];
    logic [P-1:0] data_log  [$];
    int           dut_acks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy",        32'(busy),        32'(exp_busy));
            chk("enc_reset",   32'(enc_reset),   32'(exp_rst));
            chk("enc_enable",  32'(enc_enable),  32'(exp_en));
            chk("ack",         32'(ack),         32'(exp_ack));
            chk("grant_id",    32'(grant_id),    32'(exp_grant));
            chk("enc_data",    32'(enc_data),    32'(exp_data));
            chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
        end
        if (ack != '0) dut_acks++;
    end

    task automatic model_reset();
        rr_last = N - 1;
        m_grant = 0;
        m_data  = '0;
        m_terr  = 1'b0;
        in_pkt  = 1'b0;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            int c;
            logic [N-1:0] s;
            c = (last + i) % N;
            s = r >> c;
            if (s[0]) return c;
        end
        return -1;
    endfunction

    task automatic drive_inputs(input logic [N-1:0] e_ack);
        if (src_mode == 0) begin
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) begin
                    if ($urandom_range(1, 0) == 0) pend[i] = 1'b0;
                    else sdata[i] = P'($urandom);
                end else if (!pend[i]) begin
                    if ($urandom_range(5, 0) == 0) begin
                        pend[i]  = 1'b1;
                        sdata[i] = P'($urandom);
                    end
                end else if ($urandom_range(9, 0) == 0) begin
                    sdata[i] = P'($urandom);
                end else if (in_pkt && i == m_grant && $urandom_range(29, 0) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
        req = pend;
        for (int i = 0; i < N; i++) req_data[i*P +: P] = sdata[i];
        reset    = rst_drive;
        enc_done = done_never ? 1'b0 : ($urandom_range(4, 0) == 0);
    endtask

    // Publish this cycle's expectations, drive inputs, advance to just after the edge.
    task automatic run_cycle(input bit b, input bit r, input bit e, input logic [N-1:0] a);
        exp_busy  = b;
        exp_rst   = r;
        exp_en    = e;
        exp_ack   = a;
        exp_grant = 3'(m_grant);
        exp_data  = m_data;
        exp_terr  = m_terr;
        chk_en    = 1'b1;
        drive_inputs(a);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_drive = 1'b1;
        run_cycle(1'b0, 1'b1, 1'b0, '0);
        model_reset();
        for (int i = 1; i < cycles; i++) run_cycle(1'b0, 1'b1, 1'b0, '0);
        rst_drive = 1'b0;
    endtask

    // One complete grant as seen from the sources; abort pulses reset mid-SEND.
    task automatic do_packet(input bit abort);
        int           idle_n;
        int           g;
        int           n;
        int           npk;
        bit           timed_out;
        logic [P-1:0] words [2];
        idle_n    = 0;
        timed_out = 1'b0;
        in_pkt    = 1'b0;
        forever begin
            run_cycle(1'b0, 1'b1, 1'b0, '0);
            if (req != '0) break;
            idle_n++;
            if (idle_n > 400) return;
        end
        g       = pick(req, rr_last);
        rr_last = g;
        m_grant = g;
        in_pkt  = 1'b1;
        grant_log.push_back(g);
`ifdef LIO_TX_SRC_HEADER_EN
        words[0] = {{(P-3){1'b1}}, 3'(g)};
        words[1] = P'(req_data >> (g * P));
        npk      = 2;
`else
        words[0] = P'(req_data >> (g * P));
        words[1] = '0;
        npk      = 1;
`endif
        for (int k = 0; k < npk; k++) begin
            m_data = words[k];
            data_log.push_back(m_data);
            repeat (R) run_cycle(1'b1, 1'b1, 1'b0, '0);
            n = 0;
            forever begin
                n++;
                if (abort && n == 3) rst_drive = 1'b1;
                run_cycle(1'b1, 1'b0, 1'b1, '0);
                if (rst_drive) begin
                    rst_drive = 1'b0;
                    model_reset();
                    return;
                end
                if (enc_done) break;
                if (n == T) begin
                    m_terr    = 1'b1;
                    timed_out = 1'b1;
                    break;
                end
            end
            if (timed_out) break;
        end
        run_cycle(1'b1, 1'b1, 1'b0, N'(1) << g);
        in_pkt = 1'b0;
        repeat (G) run_cycle(1'b1, 1'b1, 1'b0, '0);
    endtask

    initial begin
        int acks0;
        reset      = 1'b1;
        req        = '0;
        req_data   = '0;
        enc_done   = 1'b0;
        rst_drive  = 1'b1;
        done_never = 1'b0;
        src_mode   = 1;
        pend       = '0;
        sdata[0] = 8'hB6; sdata[1] = 8'hF4; sdata[2] = 8'h3C; sdata[3] = 8'h81;
        model_reset();
        @(posedge clock);
        #1;
        do_reset(2);

        // single source from reset
        pend  = 4'b0001;
        acks0 = dut_acks;
        do_packet(1'b0);
        chk("t1_grant", 32'(grant_log[0]), 32'd0);
        chk("t1_acks", 32'(dut_acks - acks0), 32'd1);
`ifndef LIO_TX_SRC_HEADER_EN
        chk("t1_model_data", 32'(data_log[0]), 32'hB6);
        chk("t1_dut_data", 32'(enc_data), 32'hB6);
`endif

        // all four held: rotation 0,1,2,3,0
        do_reset(2);
        pend = 4'b1111;
        grant_log.delete();
        data_log.delete();
        acks0 = dut_acks;
        repeat (5) do_packet(1'b0);
        chk("t2_acks", 32'(dut_acks - acks0), 32'd5);
        for (int i = 0; i < 5; i++) chk("t2_order", 32'(grant_log[i]), 32'(i % 4));
`ifndef LIO_TX_SRC_HEADER_EN
        chk("t2_data0", 32'(data_log[0]), 32'hB6);
        chk("t2_data2", 32'(data_log[2]), 32'h3C);
        chk("t2_data4", 32'(data_log[4]), 32'hB6);
`endif

        // rr_last=1 with req 1001: source 3 ahead of source 0
        do_reset(2);
        pend = 4'b0010;
        grant_log.delete();
        do_packet(1'b0);
        pend = 4'b1001;
        do_packet(1'b0);
        do_packet(1'b0);
        chk("t3_first", 32'(grant_log[1]), 32'd3);
        chk("t3_second", 32'(grant_log[2]), 32'd0);

        // encoder never finishes: timeout, ack, then service continues
        do_reset(2);
        done_never = 1'b1;
        pend  = 4'b0100;
        acks0 = dut_acks;
        do_packet(1'b0);
        chk("t4_terr", 32'(timeout_err), 32'd1);
        chk("t4_ack", 32'(dut_acks - acks0), 32'd1);
        done_never = 1'b0;
        pend = 4'b0001;
        grant_log.delete();
        do_packet(1'b0);
        chk("t4_next_grant", 32'(grant_log[0]), 32'd0);
        chk("t4_terr_sticky", 32'(timeout_err), 32'd1);

        // reset in SEND of source 2, req held: back to source 0
        do_reset(2);
        pend = 4'b1111;
        grant_log.delete();
        do_packet(1'b0);
        do_packet(1'b0);
        done_never = 1'b1;
        acks0 = dut_acks;
        do_packet(1'b1);
        done_never = 1'b0;
        chk("t5_enc_data", 32'(enc_data), 32'd0);
        chk("t5_enc_reset", 32'(enc_reset), 32'd1);
        chk("t5_terr", 32'(timeout_err), 32'd0);
        do_packet(1'b0);
        chk("t5_no_ack2", 32'(dut_acks - acks0), 32'd1);
        chk("t5_regrant", 32'(grant_log[3]), 32'd0);

`ifdef LIO_TX_SRC_HEADER_EN
        // header then payload, one ack
        do_reset(2);
        pend     = 4'b0100;
        sdata[2] = 8'h5A;
        data_log.delete();
        acks0 = dut_acks;
        do_packet(1'b0);
        chk("hdr_word", 32'(data_log[0]), 32'hFA);
        chk("hdr_payload", 32'(data_log[1]), 32'h5A);
        chk("hdr_dut_data", 32'(enc_data), 32'h5A);
        chk("hdr_acks", 32'(dut_acks - acks0), 32'd1);
`endif

        // randomized sources and encoder latency
        do_reset(2);
        src_mode = 0;
        pend     = '0;
        repeat (40) do_packet(1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
